// File: rtl/reg_bus_initiator.sv
// ----------------------------------------------------------------------------
// reg_bus_initiator
//
// Initiator side of the peripheral register bus. Commands (read / write /
// poll) arrive on a valid/ready port and are buffered in a small FIFO. One
// command at a time is popped into a working register. The command is then
// executed as single-cycle strobes towards a register-top responder. Exactly
// one response is returned per command, in command order.
//
// Optional feature, enabled by defining REG_INIT_WR_VERIFY_EN:
//   Every write strobe is followed by one read-back strobe at the same
//   address. The enabled byte lanes are compared with the written data.
//   The response carries the read-back value and err=1 on a mismatch.
//
// Parameters
//   CMD_DEPTH     command FIFO entries (power of 2, >= 2)
//   POLL_W        width of poll_limit_i and the poll counter
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake (ready = FIFO not full)
//   cmd_op_i              00 read, 01 write, 10 poll, 11 reserved
//   cmd_addr_i            register byte address
//   cmd_wdata_i           write data / poll compare value
//   cmd_mask_i            poll bit mask
//   cmd_be_i              byte enables
//   poll_limit_i          max poll reads (0 = unlimited), sampled at pop
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read / poll / verify data
//   rsp_err_o             poll limit hit, reserved op, verify mismatch
//   busy_o                FIFO non-empty or FSM not idle
//   reg_we_o, reg_re_o    bus write / read strobes
//   reg_addr_o            bus address
//   reg_wdata_o           bus write data
//   reg_be_o              bus byte enables
//   reg_rdata_i           bus read data, valid with reg_re_o
// ----------------------------------------------------------------------------
module reg_bus_initiator #(
  parameter int CMD_DEPTH = 4,
  parameter int POLL_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [31:0]       cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  input  logic [31:0]       cmd_mask_i,
  input  logic [3:0]        cmd_be_i,
  input  logic [POLL_W-1:0] poll_limit_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  output logic [31:0]       reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  output logic [3:0]        reg_be_o,
  input  logic [31:0]       reg_rdata_i
);

  localparam int AW    = $clog2(CMD_DEPTH);
  localparam int ENT_W = 2 + 32 + 32 + 32 + 4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

`ifdef REG_INIT_WR_VERIFY_EN
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, VERIFY, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, RESP} state_t;
`endif

  // --------------------------------------------------------------------------
  // Command FIFO. The pointers carry one extra wrap bit so that full and
  // empty can be told apart without a separate counter.
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0] fifo_mem [CMD_DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  state_t           state_reg;

  assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign cmd_ready_o = !fifo_full;
  // Readiness depends only on the registered full flag. A push into a full
  // FIFO is therefore refused even when a pop happens in the same cycle.
  assign push        = cmd_valid_i && !fifo_full;
  assign pop         = (state_reg == IDLE) && !fifo_empty;
  assign busy_o      = !fifo_empty || (state_reg != IDLE);

  // The storage has no reset. Only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {cmd_op_i, cmd_addr_i, cmd_wdata_i, cmd_mask_i, cmd_be_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  logic [ENT_W-1:0] head;
  logic [1:0]       head_op;
  logic [31:0]      head_addr;
  logic [31:0]      head_wdata;
  logic [31:0]      head_mask;
  logic [3:0]       head_be;

  assign head = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign {head_op, head_addr, head_wdata, head_mask, head_be} = head;

  // --------------------------------------------------------------------------
  // Working register and poll bookkeeping
  // --------------------------------------------------------------------------
  logic [1:0]        w_op_reg;
  logic [31:0]       w_addr_reg;
  logic [31:0]       w_wdata_reg;
  logic [31:0]       w_mask_reg;
  logic [3:0]        w_be_reg;
  logic [POLL_W-1:0] w_limit_reg;
  logic [POLL_W-1:0] poll_cnt_reg;
  logic [POLL_W-1:0] poll_cnt_next;
  logic              poll_match;
  logic              poll_exhausted;

  assign poll_cnt_next  = poll_cnt_reg + POLL_W'(1);
  assign poll_match     = ((reg_rdata_i & w_mask_reg) == (w_wdata_reg & w_mask_reg));
  // With an unlimited poll (limit 0), the counter is allowed to wrap silently.
  assign poll_exhausted = (w_limit_reg != '0) && (poll_cnt_next == w_limit_reg);

`ifdef REG_INIT_WR_VERIFY_EN
  // Expand the byte enables into a bit mask for the read-back compare.
  logic [31:0] lane_mask;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_mask[gi*8 +: 8] = {8{w_be_reg[gi]}};
  end
`endif

  // --------------------------------------------------------------------------
  // Control FSM. All bus and response outputs are registered here. A strobe
  // is asserted on the same edge that enters the strobe state, so the strobe
  // is visible for exactly the cycle that the FSM spends in that state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      reg_we_o     <= 1'b0;
      reg_re_o     <= 1'b0;
      reg_addr_o   <= '0;
      reg_wdata_o  <= '0;
      reg_be_o     <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_err_o    <= 1'b0;
      rsp_rdata_o  <= '0;
      w_op_reg     <= '0;
      w_addr_reg   <= '0;
      w_wdata_reg  <= '0;
      w_mask_reg   <= '0;
      w_be_reg     <= '0;
      w_limit_reg  <= '0;
      poll_cnt_reg <= '0;
    end else begin
      // The bus is idle (all zero) unless a strobe is being launched below.
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_be_o    <= '0;

      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            w_op_reg     <= head_op;
            w_addr_reg   <= head_addr;
            w_wdata_reg  <= head_wdata;
            w_mask_reg   <= head_mask;
            w_be_reg     <= head_be;
            w_limit_reg  <= poll_limit_i;
            poll_cnt_reg <= '0;
            if (head_op == 2'b11) begin
              // A reserved op makes no bus access and goes straight to an error response.
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
              state_reg   <= RESP;
            end else begin
              reg_we_o    <= (head_op == OP_WRITE);
              reg_re_o    <= (head_op != OP_WRITE);
              reg_addr_o  <= head_addr;
              reg_wdata_o <= head_wdata;
              reg_be_o    <= head_be;
              state_reg   <= ISSUE;
            end
          end
        end

        ISSUE: begin
          case (w_op_reg)
            OP_READ: begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= reg_rdata_i;
              state_reg   <= RESP;
            end
            OP_WRITE: begin
`ifdef REG_INIT_WR_VERIFY_EN
              reg_re_o    <= 1'b1;
              reg_addr_o  <= w_addr_reg;
              reg_be_o    <= w_be_reg;
              state_reg   <= VERIFY;
`else
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= '0;
              state_reg   <= RESP;
`endif
            end
            OP_POLL: begin
              if (poll_match || poll_exhausted) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= !poll_match;
                rsp_rdata_o <= reg_rdata_i;
                state_reg   <= RESP;
              end else begin
                poll_cnt_reg <= poll_cnt_next;
                state_reg    <= GAP;
              end
            end
            default: begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
              state_reg   <= RESP;
            end
          endcase
        end

        // One quiet cycle between poll reads, then the next read is launched.
        GAP: begin
          reg_re_o    <= 1'b1;
          reg_addr_o  <= w_addr_reg;
          reg_wdata_o <= w_wdata_reg;
          reg_be_o    <= w_be_reg;
          state_reg   <= ISSUE;
        end

`ifdef REG_INIT_WR_VERIFY_EN
        VERIFY: begin
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= reg_rdata_i;
          rsp_err_o   <= (((reg_rdata_i ^ w_wdata_reg) & lane_mask) != '0);
          state_reg   <= RESP;
        end
`endif

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state_reg   <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// ----------------------------------------------------------------------------
// tb_reg_bus_initiator
//
// Self-checking bench for reg_bus_initiator. A simple register-file responder
// sits on the bus side. It has one special poll address whose status bit
// becomes set after a chosen number of reads, and one address that drops
// byte 3 on writes. Expected responses come from a command-level model:
// one array indexed by register, updated in command order. Strobe timing is
// taken from a log of every strobe cycle that is seen.
// ----------------------------------------------------------------------------
module tb_reg_bus_initiator;

  localparam int          CMD_DEPTH = 4;
  localparam int          POLL_W    = 16;
  localparam logic [31:0] POLL_ADDR = 32'h0000_0040;
  localparam logic [31:0] DROP_ADDR = 32'h0000_003C;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [31:0]       cmd_addr = '0;
  logic [31:0]       cmd_wdata = '0;
  logic [31:0]       cmd_mask = '0;
  logic [3:0]        cmd_be = '0;
  logic [POLL_W-1:0] poll_limit = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              reg_we;
  logic              reg_re;
  logic [31:0]       reg_addr;
  logic [31:0]       reg_wdata;
  logic [3:0]        reg_be;
  logic [31:0]       reg_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_bus_initiator #(.CMD_DEPTH(CMD_DEPTH), .POLL_W(POLL_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
    .cmd_be_i(cmd_be), .poll_limit_i(poll_limit),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .reg_we_o(reg_we), .reg_re_o(reg_re), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_be_o(reg_be), .reg_rdata_i(reg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- responder ----------------
  logic [31:0] bus_mem [16];
  int poll_reads = 0;
  int poll_base = 0;
  int poll_target = 1000;

  always @(posedge clk) begin
    if (reg_we) begin
      for (int b = 0; b < 4; b++) begin
        if (reg_be[b]) begin
          bus_mem[reg_addr[5:2]][b*8 +: 8] <= (reg_addr == DROP_ADDR && b == 3) ? 8'h00 : reg_wdata[b*8 +: 8];
        end
      end
    end
    if (reg_re && reg_addr == POLL_ADDR) poll_reads <= poll_reads + 1;
  end

  // Poll register: the read number is in bits [15:4]; bit 2 is set from read poll_target onward.
  always_comb begin
    int k;
    reg_rdata = 32'h0;
    k = poll_reads - poll_base + 1;
    if (reg_re) begin
      if (reg_addr == POLL_ADDR) begin
        reg_rdata = {16'hA5A5, 12'(k - 1), 4'h0};
        if (k >= poll_target) reg_rdata[2] = 1'b1;
      end else begin
        reg_rdata = bus_mem[reg_addr[5:2]];
      end
    end
  end

  // ---------------- strobe monitor ----------------
  typedef struct {
    int          c;
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } strb_t;
  strb_t slog[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we || reg_re) begin
        slog.push_back('{cyc, reg_we, reg_re, reg_addr, reg_wdata, reg_be});
        chk("we_re_exclusive", 32'(reg_we && reg_re), 32'd0);
      end else begin
        chk("bus_idle_zero", reg_addr | reg_wdata | 32'(reg_be), 32'd0);
      end
    end
  end

  // ---------------- command-level reference model ----------------
  logic [31:0] ref_mem [16];

  task automatic model_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] rd, output logic er);
    logic [31:0] lm;
    rd = 32'h0;
    er = 1'b0;
    case (op)
      2'b00: rd = ref_mem[a[5:2]];
      2'b01: begin
        for (int b = 0; b < 4; b++) begin
          lm[b*8 +: 8] = {8{be[b]}};
          if (be[b]) ref_mem[a[5:2]][b*8 +: 8] = (a == DROP_ADDR && b == 3) ? 8'h00 : d[b*8 +: 8];
        end
`ifdef REG_INIT_WR_VERIFY_EN
        rd = ref_mem[a[5:2]];
        er = ((rd ^ d) & lm) != 32'h0;
`endif
      end
      default: er = 1'b1;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] m, input logic [3:0] be, output int acc);
    int t = 0;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_mask = m; cmd_be = be;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", 32'(t >= 200), 32'd0);
    acc = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits for a response and holds rsp_ready low for 'hold' cycles. During that time
  // it checks that the data stays stable. Then it completes the handshake.
  task automatic get_rsp(input int hold, output logic [31:0] rd, output logic er, output int c);
    int t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_timeout", 32'(t >= 300), 32'd0);
    rd = rsp_rdata;
    er = rsp_err;
    c  = cyc;
    if (hold > 0) begin
      rsp_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk("rsp_hold_data", rsp_rdata, rd);
        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, c, t;
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    logic [1:0]  q_op [6];
    logic [31:0] q_a  [6];
    logic [31:0] q_d  [6];
    logic [3:0]  q_be [6];
    logic [31:0] exp_q_rd [$];
    logic        exp_q_er [$];

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({reg_we, reg_re}), 32'd0);
    chk("rst_rdata_err", rsp_rdata | 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- 1: write latency and strobe contents ----
    slog.delete();
    model_cmd(2'b01, 32'h04, 32'h10, 4'hF, exp_rd, exp_er);
    send(2'b01, 32'h04, 32'h0000_0010, 32'h0, 4'hF, acc);
    get_rsp(0, rd, er, c);
`ifdef REG_INIT_WR_VERIFY_EN
    chk("wr_strobe_count", 32'(slog.size()), 32'd2);
    chk("wr_rsp_latency", 32'(c - acc), 32'd4);
`else
    chk("wr_strobe_count", 32'(slog.size()), 32'd1);
    chk("wr_rsp_latency", 32'(c - acc), 32'd3);
`endif
    chk("wr_strobe_cycle", 32'(slog[0].c - acc), 32'd2);
    chk("wr_strobe_we", 32'({slog[0].we, slog[0].re}), 32'd2);
    chk("wr_strobe_addr", slog[0].a, 32'h04);
    chk("wr_strobe_wdata", slog[0].d, 32'h10);
    chk("wr_strobe_be", 32'(slog[0].be), 32'hF);
    chk("wr_rsp_rdata", rd, exp_rd);
    chk("wr_rsp_err", 32'(er), 32'(exp_er));
    @(negedge clk);
    chk("wr_busy_after", 32'(busy), 32'd0);

    // ---- 2: read 0x08 after writing DEADBEEF ----
    model_cmd(2'b01, 32'h08, 32'hDEADBEEF, 4'hF, exp_rd, exp_er);
    send(2'b01, 32'h08, 32'hDEADBEEF, 32'h0, 4'hF, acc);
    get_rsp(0, rd, er, c);
    slog.delete();
    model_cmd(2'b00, 32'h08, 32'h0, 4'hF, exp_rd, exp_er);
    send(2'b00, 32'h08, 32'h0, 32'h0, 4'hF, acc);
    get_rsp(0, rd, er, c);
    chk("rd_strobe_count", 32'(slog.size()), 32'd1);
    chk("rd_strobe_re", 32'({slog[0].we, slog[0].re}), 32'd1);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);
    chk("rd_latency", 32'(c - acc), 32'd3);

    // ---- 3: poll that matches on the 6th read ----
    slog.delete();
    poll_base = poll_reads; poll_target = 6; poll_limit = 16'd0;
    send(2'b10, POLL_ADDR, 32'h4, 32'h4, 4'hF, acc);
    get_rsp(0, rd, er, c);
    chk("poll_reads", 32'(slog.size()), 32'd6);
    for (int i = 1; i < slog.size(); i++) chk("poll_spacing", 32'(slog[i].c - slog[i-1].c), 32'd2);
    chk("poll_err", 32'(er), 32'd0);
    chk("poll_rdata", rd, 32'hA5A5_0054);

    // ---- 4: poll limit 3 never matching, then reserved op ----
    slog.delete();
    poll_base = poll_reads; poll_target = 1000; poll_limit = 16'd3;
    send(2'b10, POLL_ADDR, 32'h4, 32'h4, 4'hF, acc);
    get_rsp(0, rd, er, c);
    chk("plim_reads", 32'(slog.size()), 32'd3);
    chk("plim_err", 32'(er), 32'd1);
    chk("plim_rdata", rd, 32'hA5A5_0020);
    slog.delete();
    send(2'b11, 32'h08, 32'h1, 32'h0, 4'hF, acc);
    get_rsp(0, rd, er, c);
    chk("rsv_strobes", 32'(slog.size()), 32'd0);
    chk("rsv_err", 32'(er), 32'd1);
    chk("rsv_rdata", rd, 32'h0);

    // ---- mask 0 matches on the first read ----
    slog.delete();
    poll_base = poll_reads; poll_limit = 16'd0;
    send(2'b10, POLL_ADDR, 32'h4, 32'h0, 4'hF, acc);
    get_rsp(0, rd, er, c);
    chk("mask0_reads", 32'(slog.size()), 32'd1);
    chk("mask0_err", 32'(er), 32'd0);
    chk("mask0_rdata", rd, 32'hA5A5_0000);

    // ---- fill register file with known contents ----
    for (int i = 0; i < 15; i++) begin
      logic [31:0] v;
      v = $urandom;
      model_cmd(2'b01, 32'(i * 4), v, 4'hF, exp_rd, exp_er);
      send(2'b01, 32'(i * 4), v, 32'h0, 4'hF, acc);
      get_rsp(0, rd, er, c);
    end

    // ---- 5: back-pressure, FIFO full, in-order responses ----
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q_op[i] = (i % 2 == 0) ? 2'b01 : 2'b00;
      q_a[i]  = 32'(($urandom_range(0, 14)) * 4);
      q_d[i]  = $urandom;
      q_be[i] = 4'($urandom_range(1, 15));
      if (i > 0 && q_op[i] == 2'b00) q_a[i] = q_a[i-1];
      model_cmd(q_op[i], q_a[i], q_d[i], q_be[i], exp_rd, exp_er);
      exp_q_rd.push_back(exp_rd);
      exp_q_er.push_back(exp_er);
    end
    for (int i = 0; i < 5; i++) send(q_op[i], q_a[i], q_d[i], 32'h0, q_be[i], acc);
    repeat (3) @(negedge clk);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    fork
      send(q_op[5], q_a[5], q_d[5], 32'h0, q_be[5], acc);
      begin
        repeat (3) @(negedge clk);
        chk("full_refuse", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
          get_rsp(0, rd, er, c);
          chk("order_rdata", rd, exp_q_rd.pop_front());
          chk("order_err", 32'(er), 32'(exp_q_er.pop_front()));
        end
      end
    join
    @(negedge clk);
    chk("busy_after_last", 32'(busy), 32'd0);

    // ---- randomized reads/writes/reserved against the model ----
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [31:0] a, d;
      logic [3:0] be;
      t  = $urandom_range(0, 9);
      op = (t == 0) ? 2'b11 : ((t < 5) ? 2'b00 : 2'b01);
      a  = 32'(($urandom_range(0, 14)) * 4);
      d  = $urandom;
      be = 4'($urandom);
      model_cmd(op, a, d, be, exp_rd, exp_er);
      send(op, a, d, 32'h0, be, acc);
      get_rsp($urandom_range(0, 3), rd, er, c);
      chk("rand_rdata", rd, exp_rd);
      chk("rand_err", 32'(er), 32'(exp_er));
    end

    // ---- 6: reset during an unlimited poll with a command queued ----
    poll_base = poll_reads; poll_target = 1000; poll_limit = 16'd0;
    send(2'b10, POLL_ADDR, 32'h4, 32'h4, 4'hF, acc);
    send(2'b00, 32'h00, 32'h0, 32'h0, 4'hF, acc);
    repeat (4) @(negedge clk);
    t = 0;
    while (!reg_re && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("mid_poll_strobe_seen", 32'(reg_re), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_re", 32'(reg_re), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    slog.delete();
    repeat (6) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_strobes", 32'(slog.size()), 32'd0);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

    // ---- write to the byte-3-dropping register ----
    model_cmd(2'b01, DROP_ADDR, 32'hAABBCCDD, 4'hF, exp_rd, exp_er);
    send(2'b01, DROP_ADDR, 32'hAABBCCDD, 32'h0, 4'hF, acc);
    get_rsp(0, rd, er, c);
`ifdef REG_INIT_WR_VERIFY_EN
    chk("verify_rdata", rd, 32'h00BBCCDD);
    chk("verify_err", 32'(er), 32'd1);
`else
    chk("drop_wr_rdata", rd, exp_rd);
    chk("drop_wr_err", 32'(er), 32'(exp_er));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
